// File: rtl/sda_kernel_dispatch_scheduler.sv
// Kernel dispatch scheduler: shares NumSlots kernel instances between one
// upstream go/done channel. Go requests are dispatched round-robin to idle
// slots; completions are returned round-robin, tagged with their slot index.
module sda_kernel_dispatch_scheduler #(
  parameter int unsigned NumSlots    = 4,
  parameter int unsigned SlotIdWidth = 2,
  parameter int unsigned CountWidth  = 3
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   regGoValid,
  output logic                   regGoHoldoff,
  output logic                   regDoneValid,
  input  logic                   regDoneStop,
  output logic [SlotIdWidth-1:0] regDoneSlot,
  output logic [NumSlots-1:0]    slotGoValid,
  input  logic [NumSlots-1:0]    slotGoHoldoff,
  input  logic [NumSlots-1:0]    slotDoneValid,
  output logic [NumSlots-1:0]    slotDoneStop,
  output logic [CountWidth-1:0]  activeCount,
  output logic                   busy
);

  typedef enum logic [1:0] {
    SlotIdle   = 2'd0,
    SlotLaunch = 2'd1,
    SlotBusy   = 2'd2,
    SlotDone   = 2'd3
  } slotState_e;

  slotState_e slotState     [NumSlots];
  slotState_e slotStateNext [NumSlots];

  logic [SlotIdWidth-1:0] goPtr;
  logic [SlotIdWidth-1:0] goPtrNext;
  logic [SlotIdWidth-1:0] donePtr;
  logic [SlotIdWidth-1:0] donePtrNext;

  logic                   goAccept;
  logic                   doneAccept;
  logic [NumSlots-1:0]    idleVec;
  logic [NumSlots-1:0]    doneEligVec;
  logic [NumSlots-1:0]    idleNextVec;
  logic                   goFound;
  logic [SlotIdWidth-1:0] goSel;
  logic                   doneFound;
  logic [SlotIdWidth-1:0] doneSel;

  logic                   regGoHoldoffNext;
  logic                   regDoneValidNext;
  logic [SlotIdWidth-1:0] regDoneSlotNext;
  logic [NumSlots-1:0]    slotGoValidNext;
  logic [NumSlots-1:0]    slotDoneStopNext;
  logic [CountWidth-1:0]  activeCountNext;
  logic                   busyNext;

  // First requesting slot scanning upward from ptr with wrap; MSB flags a hit.
  function automatic logic [SlotIdWidth:0] pickFirst(
    input logic [NumSlots-1:0]    req,
    input logic [SlotIdWidth-1:0] ptr
  );
    logic                   found;
    logic [SlotIdWidth-1:0] sel;
    logic [SlotIdWidth-1:0] idx;
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      idx = SlotIdWidth'((32'(ptr) + i) % NumSlots);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  assign goAccept   = regGoValid & ~regGoHoldoff;
  assign doneAccept = regDoneValid & ~regDoneStop;

  // Candidate vectors and round-robin picks for go dispatch and done return.
  always_comb begin
    idleVec     = '0;
    doneEligVec = '0;
    for (int s = 0; s < NumSlots; s++) begin
      idleVec[s]     = (slotState[s] == SlotIdle);
      // The completion already sitting in the output register is not reloaded.
      doneEligVec[s] = (slotState[s] == SlotDone) &&
                       !(regDoneValid && (regDoneSlot == SlotIdWidth'(s)));
    end
    {goFound, goSel}     = pickFirst(idleVec, goPtr);
    {doneFound, doneSel} = pickFirst(doneEligVec, donePtr);
  end

  // Next-state for slot FSMs, pointers and all registered outputs.
  always_comb begin
    for (int s = 0; s < NumSlots; s++) begin
      slotStateNext[s] = slotState[s];
    end
    goPtrNext        = goPtr;
    donePtrNext      = donePtr;
    regDoneValidNext = regDoneValid;
    regDoneSlotNext  = regDoneSlot;
    activeCountNext  = activeCount;
    idleNextVec      = '0;
    slotGoValidNext  = '0;
    slotDoneStopNext = '1;
    regGoHoldoffNext = 1'b1;
    busyNext         = 1'b0;

    for (int s = 0; s < NumSlots; s++) begin
      case (slotState[s])
        SlotIdle: begin
          if (goAccept && goFound && (goSel == SlotIdWidth'(s))) begin
            slotStateNext[s] = SlotLaunch;
          end
        end
        SlotLaunch: begin
          if (slotGoValid[s] && !slotGoHoldoff[s]) begin
            slotStateNext[s] = SlotBusy;
          end
        end
        SlotBusy: begin
          if (slotDoneValid[s] && !slotDoneStop[s]) begin
            slotStateNext[s] = SlotDone;
          end
        end
        SlotDone: begin
          if (doneAccept && (regDoneSlot == SlotIdWidth'(s))) begin
            slotStateNext[s] = SlotIdle;
          end
        end
        default: slotStateNext[s] = SlotIdle;
      endcase
    end

    if (goAccept && goFound) begin
      goPtrNext = SlotIdWidth'((32'(goSel) + 32'd1) % NumSlots);
    end

    // Output register refills in the same cycle it drains.
    if (!regDoneValid || doneAccept) begin
      if (doneFound) begin
        regDoneValidNext = 1'b1;
        regDoneSlotNext  = doneSel;
        donePtrNext      = SlotIdWidth'((32'(doneSel) + 32'd1) % NumSlots);
      end else begin
        regDoneValidNext = 1'b0;
      end
    end

    case ({goAccept && goFound, doneAccept})
      2'b10: begin
        if (activeCount != CountWidth'(NumSlots)) begin
          activeCountNext = activeCount + CountWidth'(1);
        end
      end
      2'b01: begin
        if (activeCount != '0) begin
          activeCountNext = activeCount - CountWidth'(1);
        end
      end
      default: activeCountNext = activeCount;
    endcase

    for (int s = 0; s < NumSlots; s++) begin
      idleNextVec[s]      = (slotStateNext[s] == SlotIdle);
      slotGoValidNext[s]  = (slotStateNext[s] == SlotLaunch);
      slotDoneStopNext[s] = (slotStateNext[s] != SlotBusy);
    end

    // Holdoff after every accept spaces accepts two cycles apart.
    regGoHoldoffNext = goAccept | ~(|idleNextVec);
    busyNext         = (activeCountNext != '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int s = 0; s < NumSlots; s++) begin
        slotState[s] <= SlotIdle;
      end
      goPtr        <= '0;
      donePtr      <= '0;
      regGoHoldoff <= 1'b1;
      regDoneValid <= 1'b0;
      regDoneSlot  <= '0;
      slotGoValid  <= '0;
      slotDoneStop <= '1;
      activeCount  <= '0;
      busy         <= 1'b0;
    end else begin
      for (int s = 0; s < NumSlots; s++) begin
        slotState[s] <= slotStateNext[s];
      end
      goPtr        <= goPtrNext;
      donePtr      <= donePtrNext;
      regGoHoldoff <= regGoHoldoffNext;
      regDoneValid <= regDoneValidNext;
      regDoneSlot  <= regDoneSlotNext;
      slotGoValid  <= slotGoValidNext;
      slotDoneStop <= slotDoneStopNext;
      activeCount  <= activeCountNext;
      busy         <= busyNext;
    end
  end

endmodule

// File: tb/tb_sda_kernel_dispatch_scheduler.sv
// Self-checking bench for sda_kernel_dispatch_scheduler (4 slots).
module tb_sda_kernel_dispatch_scheduler;

  logic       clk;
  logic       rstN;
  logic       regGoValid;
  logic       regGoHoldoff;
  logic       regDoneValid;
  logic       regDoneStop;
  logic [1:0] regDoneSlot;
  logic [3:0] slotGoValid;
  logic [3:0] slotGoHoldoff;
  logic [3:0] slotDoneValid;
  logic [3:0] slotDoneStop;
  logic [2:0] activeCount;
  logic       busy;

  int assertCount;
  int failCount;
  int cyc;
  int goQ[$];
  int doneQ[$];

  sda_kernel_dispatch_scheduler #(
    .NumSlots(4),
    .SlotIdWidth(2),
    .CountWidth(3)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .regGoValid(regGoValid),
    .regGoHoldoff(regGoHoldoff),
    .regDoneValid(regDoneValid),
    .regDoneStop(regDoneStop),
    .regDoneSlot(regDoneSlot),
    .slotGoValid(slotGoValid),
    .slotGoHoldoff(slotGoHoldoff),
    .slotDoneValid(slotDoneValid),
    .slotDoneStop(slotDoneStop),
    .activeCount(activeCount),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop expected slot on every per-slot launch and upstream completion.
  always @(negedge clk) begin
    int expS;
    if (rstN) begin
      for (int s = 0; s < 4; s++) begin
        if (slotGoValid[s] && !slotGoHoldoff[s]) begin
          assertCount++;
          if (goQ.size() == 0) begin
            failCount++;
            $display("FAIL go_launch: slot %0d launched, no launch expected", s);
          end else begin
            expS = goQ.pop_front();
            if (s != expS) begin
              failCount++;
              $display("FAIL go_launch: slot %0d launched, expected slot %0d", s, expS);
            end
          end
        end
      end
      if (regDoneValid && !regDoneStop) begin
        assertCount++;
        if (doneQ.size() == 0) begin
          failCount++;
          $display("FAIL done_return: slot %0d returned, no completion expected", regDoneSlot);
        end else begin
          expS = doneQ.pop_front();
          if (int'(regDoneSlot) != expS) begin
            failCount++;
            $display("FAIL done_return: slot %0d returned, expected slot %0d", regDoneSlot, expS);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN          = 1'b0;
    regGoValid    = 1'b0;
    regDoneStop   = 1'b0;
    slotGoHoldoff = '0;
    slotDoneValid = '0;
    step(2);
    assertCount++;
    if (goQ.size() != 0 || doneQ.size() != 0) begin
      failCount++;
      $display("FAIL scoreboard_drain: go=%0d done=%0d pending, expected 0 0", goQ.size(), doneQ.size());
    end
    goQ.delete();
    doneQ.delete();
    rstN = 1'b1;
    step(1);
  endtask

  // Waits (bounded) for holdoff low, then offers one go for a single cycle.
  task automatic issueGo(input int expSlot, output int acceptCyc);
    int waitCnt;
    waitCnt   = 0;
    acceptCyc = -1;
    while (regGoHoldoff !== 1'b0 && waitCnt < 50) begin
      step(1);
      waitCnt++;
    end
    assertCount++;
    if (regGoHoldoff !== 1'b0) begin
      failCount++;
      $display("FAIL go_wait: regGoHoldoff=%b after 50 cycles, expected 0", regGoHoldoff);
    end else begin
      regGoValid = 1'b1;
      goQ.push_back(expSlot);
      step(1);
      regGoValid = 1'b0;
      acceptCyc  = cyc;
    end
  endtask

  task automatic test_reset();
    rstN          = 1'b0;
    regGoValid    = 1'b0;
    regDoneStop   = 1'b0;
    slotGoHoldoff = '0;
    slotDoneValid = '0;
    step(2);
    assertCount++;
    if (regGoHoldoff !== 1'b1) begin failCount++; $display("FAIL rst_holdoff: got %b expected 1", regGoHoldoff); end
    assertCount++;
    if (regDoneValid !== 1'b0 || regDoneSlot !== 2'd0) begin failCount++; $display("FAIL rst_done: got %b/%0d expected 0/0", regDoneValid, regDoneSlot); end
    assertCount++;
    if (slotGoValid !== 4'b0000 || slotDoneStop !== 4'b1111) begin failCount++; $display("FAIL rst_slot: got go=%b stop=%b expected 0000/1111", slotGoValid, slotDoneStop); end
    assertCount++;
    if (activeCount !== 3'd0 || busy !== 1'b0) begin failCount++; $display("FAIL rst_count: got %0d/%b expected 0/0", activeCount, busy); end
    rstN = 1'b1;
    step(1);
    assertCount++;
    if (regGoHoldoff !== 1'b0) begin failCount++; $display("FAIL rst_release_holdoff: got %b expected 0", regGoHoldoff); end
  endtask

  task automatic test_single();
    int c;
    doReset();
    issueGo(0, c);
    assertCount++;
    if (slotGoValid !== 4'b0001 || activeCount !== 3'd1 || busy !== 1'b1 || regGoHoldoff !== 1'b1) begin
      failCount++; $display("FAIL single_launch: got go=%b cnt=%0d busy=%b hold=%b expected 0001/1/1/1", slotGoValid, activeCount, busy, regGoHoldoff);
    end
    step(1);
    assertCount++;
    if (slotGoValid !== 4'b0000 || slotDoneStop !== 4'b1110) begin
      failCount++; $display("FAIL single_busy: got go=%b stop=%b expected 0000/1110", slotGoValid, slotDoneStop);
    end
    slotDoneValid = 4'b0001;
    doneQ.push_back(0);
    step(1);
    slotDoneValid = 4'b0000;
    assertCount++;
    if (slotDoneStop !== 4'b1111 || regDoneValid !== 1'b0) begin
      failCount++; $display("FAIL single_done_state: got stop=%b dv=%b expected 1111/0", slotDoneStop, regDoneValid);
    end
    step(1);
    assertCount++;
    if (regDoneValid !== 1'b1 || regDoneSlot !== 2'd0) begin
      failCount++; $display("FAIL single_present: got %b/%0d expected 1/0", regDoneValid, regDoneSlot);
    end
    step(1);
    assertCount++;
    if (regDoneValid !== 1'b0 || activeCount !== 3'd0 || busy !== 1'b0) begin
      failCount++; $display("FAIL single_return: got dv=%b cnt=%0d busy=%b expected 0/0/0", regDoneValid, activeCount, busy);
    end
  endtask

  // Fills all four slots, then leaves a fifth go pending against holdoff.
  task automatic test_fill();
    int c[4];
    doReset();
    for (int s = 0; s < 4; s++) issueGo(s, c[s]);
    for (int s = 1; s < 4; s++) begin
      assertCount++;
      if (c[s] - c[s-1] != 2) begin
        failCount++; $display("FAIL fill_spacing: accept %0d after %0d cycles, expected 2", s, c[s] - c[s-1]);
      end
    end
    step(1);
    regGoValid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      assertCount++;
      if (regGoHoldoff !== 1'b1 || activeCount !== 3'd4 || busy !== 1'b1) begin
        failCount++; $display("FAIL fill_full: cycle %0d hold=%b cnt=%0d busy=%b expected 1/4/1", k, regGoHoldoff, activeCount, busy);
      end
      step(1);
    end
    assertCount++;
    if (slotGoValid !== 4'b0000 || slotDoneStop !== 4'b0000) begin
      failCount++; $display("FAIL fill_slots: got go=%b stop=%b expected 0000/0000", slotGoValid, slotDoneStop);
    end
  endtask

  // Continues from full with a go pending: two simultaneous completions.
  task automatic test_done_pair();
    goQ.push_back(0);
    slotDoneValid = 4'b0101;
    doneQ.push_back(0);
    doneQ.push_back(2);
    step(1);
    slotDoneValid = 4'b0000;
    assertCount++;
    if (regDoneValid !== 1'b0 || activeCount !== 3'd4) begin
      failCount++; $display("FAIL pair_capture: got dv=%b cnt=%0d expected 0/4", regDoneValid, activeCount);
    end
    step(1);
    assertCount++;
    if (regDoneValid !== 1'b1 || regDoneSlot !== 2'd0 || regGoHoldoff !== 1'b1) begin
      failCount++; $display("FAIL pair_first: got %b/%0d hold=%b expected 1/0/1", regDoneValid, regDoneSlot, regGoHoldoff);
    end
    step(1);
    assertCount++;
    if (regDoneValid !== 1'b1 || regDoneSlot !== 2'd2 || activeCount !== 3'd3 || regGoHoldoff !== 1'b0) begin
      failCount++; $display("FAIL pair_second: got %b/%0d cnt=%0d hold=%b expected 1/2/3/0", regDoneValid, regDoneSlot, activeCount, regGoHoldoff);
    end
    step(1);
    regGoValid = 1'b0;
    assertCount++;
    if (slotGoValid !== 4'b0001 || regDoneValid !== 1'b0 || activeCount !== 3'd3) begin
      failCount++; $display("FAIL pair_relaunch: got go=%b dv=%b cnt=%0d expected 0001/0/3", slotGoValid, regDoneValid, activeCount);
    end
    step(1);
    assertCount++;
    if (activeCount !== 3'd3 || busy !== 1'b1 || slotDoneStop !== 4'b0100) begin
      failCount++; $display("FAIL pair_settle: got cnt=%0d busy=%b stop=%b expected 3/1/0100", activeCount, busy, slotDoneStop);
    end
  endtask

  task automatic test_done_stall();
    int c;
    doReset();
    for (int s = 0; s < 4; s++) issueGo(s, c);
    step(1);
    regDoneStop   = 1'b1;
    slotDoneValid = 4'b0010;
    doneQ.push_back(1);
    step(1);
    slotDoneValid = 4'b0000;
    step(1);
    regGoValid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      assertCount++;
      if (regDoneValid !== 1'b1 || regDoneSlot !== 2'd1 || slotGoValid !== 4'b0000 || regGoHoldoff !== 1'b1) begin
        failCount++; $display("FAIL stall_hold: cycle %0d got %b/%0d go=%b hold=%b expected 1/1/0000/1", k, regDoneValid, regDoneSlot, slotGoValid, regGoHoldoff);
      end
      step(1);
    end
    regDoneStop = 1'b0;
    goQ.push_back(1);
    step(1);
    assertCount++;
    if (regDoneValid !== 1'b0 || activeCount !== 3'd3) begin
      failCount++; $display("FAIL stall_release: got dv=%b cnt=%0d expected 0/3", regDoneValid, activeCount);
    end
    step(1);
    regGoValid = 1'b0;
    assertCount++;
    if (slotGoValid !== 4'b0010 || activeCount !== 3'd4) begin
      failCount++; $display("FAIL stall_relaunch: got go=%b cnt=%0d expected 0010/4", slotGoValid, activeCount);
    end
    step(1);
  endtask

  task automatic test_go_holdoff();
    int c;
    doReset();
    slotGoHoldoff = 4'b0001;
    issueGo(0, c);
    for (int k = 0; k < 6; k++) begin
      assertCount++;
      if (slotGoValid !== 4'b0001 || slotDoneStop[0] !== 1'b1) begin
        failCount++; $display("FAIL holdoff_hold: cycle %0d go=%b stop0=%b expected 0001/1", k, slotGoValid, slotDoneStop[0]);
      end
      if (k == 5) slotGoHoldoff = 4'b0000;
      step(1);
    end
    assertCount++;
    if (slotGoValid !== 4'b0000 || slotDoneStop !== 4'b1110 || activeCount !== 3'd1) begin
      failCount++; $display("FAIL holdoff_busy: got go=%b stop=%b cnt=%0d expected 0000/1110/1", slotGoValid, slotDoneStop, activeCount);
    end
  endtask

  task automatic test_async_reset();
    int c;
    doReset();
    issueGo(0, c);
    issueGo(1, c);
    issueGo(2, c);
    step(1);
    regDoneStop   = 1'b1;
    slotDoneValid = 4'b0010;
    step(1);
    slotDoneValid = 4'b0000;
    step(1);
    assertCount++;
    if (regDoneValid !== 1'b1 || activeCount !== 3'd3) begin
      failCount++; $display("FAIL areset_pre: got dv=%b cnt=%0d expected 1/3", regDoneValid, activeCount);
    end
    #2;
    rstN = 1'b0;
    #1;
    assertCount++;
    if (regGoHoldoff !== 1'b1 || regDoneValid !== 1'b0 || regDoneSlot !== 2'd0) begin
      failCount++; $display("FAIL areset_upstream: got hold=%b dv=%b slot=%0d expected 1/0/0", regGoHoldoff, regDoneValid, regDoneSlot);
    end
    assertCount++;
    if (slotGoValid !== 4'b0000 || slotDoneStop !== 4'b1111 || activeCount !== 3'd0 || busy !== 1'b0) begin
      failCount++; $display("FAIL areset_slots: got go=%b stop=%b cnt=%0d busy=%b expected 0000/1111/0/0", slotGoValid, slotDoneStop, activeCount, busy);
    end
    regDoneStop = 1'b0;
    step(1);
    rstN = 1'b1;
    step(1);
    issueGo(0, c);
    assertCount++;
    if (slotGoValid !== 4'b0001 || activeCount !== 3'd1) begin
      failCount++; $display("FAIL areset_redispatch: got go=%b cnt=%0d expected 0001/1", slotGoValid, activeCount);
    end
    step(1);
  endtask

  initial begin
    assertCount   = 0;
    failCount     = 0;
    cyc           = 0;
    rstN          = 1'b0;
    regGoValid    = 1'b0;
    regDoneStop   = 1'b0;
    slotGoHoldoff = '0;
    slotDoneValid = '0;
    test_reset();
    test_single();
    test_fill();
    test_done_pair();
    test_done_stall();
    test_go_holdoff();
    test_async_reset();
    step(3);
    assertCount++;
    if (goQ.size() != 0 || doneQ.size() != 0) begin
      failCount++; $display("FAIL final_drain: go=%0d done=%0d pending, expected 0 0", goQ.size(), doneQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/sda_kernel_dispatch_scheduler.md
Name: sda_kernel_dispatch_scheduler

Overview:
- Shares a pool of NumSlots kernel instances between one upstream control-register go/done channel.
- Each kernel instance sits behind its own kernel reset handler.
- Go requests are dispatched round-robin to idle slots.
- Done completions are arbitrated round-robin back upstream, tagged with the slot index.
- Sits between the control register block and the array of per-slot reset handlers.

Parameters:
- NumSlots, 4, number of kernel slots (1..2^SlotIdWidth).
- SlotIdWidth, 2, width of slot index fields.
- CountWidth, 3, width of activeCount; must hold NumSlots.

Ports:
- clk  input  1  system clock.
- rstN  input  1  asynchronous active-low reset.
- regGoValid  input  1  upstream go request.
- regGoHoldoff  output  1  upstream go backpressure; transfer when regGoValid & ~regGoHoldoff.
- regDoneValid  output  1  completion available upstream.
- regDoneStop  input  1  upstream done backpressure; transfer when regDoneValid & ~regDoneStop.
- regDoneSlot  output  SlotIdWidth  slot index of the presented completion.
- slotGoValid  output  NumSlots  per-slot go to reset handler.
- slotGoHoldoff  input  NumSlots  per-slot go backpressure.
- slotDoneValid  input  NumSlots  per-slot done from reset handler.
- slotDoneStop  output  NumSlots  per-slot done backpressure.
- activeCount  output  CountWidth  number of non-idle slots.
- busy  output  1  activeCount != 0.

Behaviour:
- All outputs are registered.
- Reset is asynchronous on rstN low. While in reset:
  - regGoHoldoff=1, regDoneValid=0, regDoneSlot=0
  - slotGoValid=0, slotDoneStop=all 1
  - activeCount=0, busy=0
  - every slot SlotIdle, goPtr=0, donePtr=0
- Reset mid-operation abandons in-flight kernels; the slot reset handlers are reset by the same system reset.
- Per-slot state machine:
  - SlotIdle -> SlotLaunch on upstream go accept selecting this slot.
  - SlotLaunch: slotGoValid[s]=1. When slotGoValid[s] & ~slotGoHoldoff[s], go to SlotBusy; slotGoValid[s]=0 next cycle.
  - SlotBusy: slotDoneStop[s]=0. When slotDoneValid[s] & ~slotDoneStop[s], go to SlotDone; slotDoneStop[s]=1 next cycle.
  - SlotDone -> SlotIdle when upstream accepts a completion whose regDoneSlot==s.
  - slotDoneStop[s]=1 in every state except SlotBusy; slotDoneValid in other states is ignored.
- Go dispatch:
  - regGoHoldoff_d = 1 if a go is accepted this cycle, or no slot will be SlotIdle in the next state; otherwise 0.
  - Result: at most one accept per 2 cycles. Holdoff deasserts 1 cycle after an idle slot appears.
  - On accept, select the first SlotIdle slot scanning upward from goPtr with wrap; set goPtr = (sel+1) mod NumSlots.
  - slotGoValid[sel] is asserted in the cycle after the accept.
- Done return:
  - Output register empty, or emptying this cycle via accept, and some slot in SlotDone not already presented: load regDoneValid=1 and regDoneSlot = first such slot scanning from donePtr; set donePtr = sel+1 mod NumSlots.
  - Loading allowed in the same cycle as an accept (back-to-back completions, one per cycle).
  - The slot whose completion is accepted becomes idle next cycle. It is not eligible for a go accept in the same cycle.
- activeCount: incremented on go accept, decremented on done accept. Both in the same cycle leave it unchanged. Never exceeds NumSlots or falls below 0.
- busy = (activeCount_d != 0), registered.

Test Plan:
- Reset release, single go with slotGoHoldoff=0: cycle 1 after accept slotGoValid=0001, dropping after 1 cycle; slot 0 Busy; activeCount=1; pulse slotDoneValid[0] -> regDoneValid=1, regDoneSlot=0; accept -> activeCount=0, busy=0.
- 5 go requests, NumSlots=4, no dones: slots 0,1,2,3 launched in order, accepts 2 cycles apart; regGoHoldoff stays 1 after the 4th; activeCount=4.
- From full, done on slots 2 and 0 in the same cycle, donePtr=0: regDoneSlot reports 0 then 2 on consecutive cycles with regDoneStop=0; the held 5th go then goes to slot 0, since goPtr=0 after wrap.
- regDoneStop=1 for 10 cycles with slot 1 done: regDoneValid and regDoneSlot=1 stay stable; slot 1 is not relaunched; accept on release frees it.
- slotGoHoldoff[0]=1 for 6 cycles: slotGoValid[0] is held for 6 cycles; slot 0 enters Busy on the 7th cycle edge.
- rstN low while 3 slots are busy and a done is pending: all outputs return to their reset values immediately (asynchronously); after release, the next go dispatches to slot 0.
